bus_host_arbiter: RTL and testbench

- Shares one downstream req/gnt/rvalid data-bus port between NrHosts requesters, e.g. core data port, a DMA and a debug host in the simple system.
- Sits between the hosts and the address-decoding bus.
- Grants round-robin, holds a stalled grant until it is accepted, and tracks outstanding transactions in an ID FIFO so responses return in order to the right host.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_arb_id_fifo.sv | 59 +++++
 rtl/bus_host_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_host_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-host bus arbiter.
package bus_arb_pkg;

  localparam int unsigned MaxHostIdW = 3;

  typedef logic [MaxHostIdW-1:0] host_id_t;

  typedef enum logic {
    ArbFree,
    ArbLocked
  } arb_state_e;

  function automatic int unsigned HostIdW(input int unsigned nr_hosts);
    return (nr_hosts <= 2) ? 1 : $clog2(nr_hosts);
  endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-flight host ID FIFO: records which host owns each accepted transaction so
// responses are routed back in order.
module bus_arb_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          i_push,
  input  logic [Width-1:0]              i_data,
  input  logic                          i_pop,
  output logic [Width-1:0]              o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(Depth+1)-1:0]    o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
  endfunction

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between NrHosts
// hosts, with grant lock on stall and in-order response routing.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NrHosts-1:0]                        host_req_i,
  output logic [NrHosts-1:0]                        host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                        host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                        host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                        host_err_o,
  output logic                                      dev_req_o,
  input  logic                                      dev_gnt_i,
  output logic [AddressWidth-1:0]                   dev_addr_o,
  output logic                                      dev_we_o,
  output logic [DataWidth/8-1:0]                    dev_be_o,
  output logic [DataWidth-1:0]                      dev_wdata_o,
  input  logic                                      dev_rvalid_i,
  input  logic [DataWidth-1:0]                      dev_rdata_i,
  input  logic                                      dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]       outstanding_o,
  output logic                                      protocol_err_o
);

  localparam int unsigned IdW = HostIdW(NrHosts);

  arb_state_e     r_state;
  arb_state_e     w_state_next;
  host_id_t       r_ptr;
  host_id_t       r_lock_id;
  host_id_t       w_winner;
  logic           w_winner_valid;
  logic           w_locked;
  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_resp;
  logic [IdW-1:0] w_head;
  logic           r_protocol_err;

  // Rotating search is done by comparing indices, so no variable-width selects.
  always_comb begin
    w_winner       = '0;
    w_winner_valid = 1'b0;
    if (w_locked) begin
      w_winner = r_lock_id;
      for (int unsigned i = 0; i < NrHosts; i++) begin
        if (r_lock_id == host_id_t'(i)) w_winner_valid = host_req_i[i];
      end
    end else begin
      for (int unsigned off = 0; off < NrHosts; off++) begin
        for (int unsigned i = 0; i < NrHosts; i++) begin
          if (!w_winner_valid && host_req_i[i] &&
              (((32'(r_ptr) + off) % NrHosts) == i)) begin
            w_winner_valid = 1'b1;
            w_winner       = host_id_t'(i);
          end
        end
      end
    end
  end

  assign dev_req_o      = w_winner_valid & ~w_full;
  assign w_accept       = dev_req_o & dev_gnt_i;
  assign w_resp         = dev_rvalid_i & ~w_empty;
  assign host_rdata_o   = {NrHosts{dev_rdata_i}};
  assign protocol_err_o = r_protocol_err;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      if (w_winner_valid && (w_winner == host_id_t'(i))) begin
        dev_addr_o    = host_addr_i[i];
        dev_we_o      = host_we_i[i];
        dev_be_o      = host_be_i[i];
        dev_wdata_o   = host_wdata_i[i];
        host_gnt_o[i] = dev_gnt_i & dev_req_o;
      end
      if (w_resp && (host_id_t'(w_head) == host_id_t'(i))) begin
        host_rvalid_o[i] = 1'b1;
        host_err_o[i]    = dev_err_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ArbFree;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ArbFree:   if (dev_req_o && !dev_gnt_i) w_state_next = ArbLocked;
      ArbLocked: if (w_accept || !w_winner_valid) w_state_next = ArbFree;
      default:   w_state_next = ArbFree;
    endcase
  end

  always_comb begin
    w_locked = (r_state == ArbLocked);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr          <= '0;
      r_lock_id      <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_accept)
        r_ptr <= (w_winner == host_id_t'(NrHosts-1)) ? '0 : w_winner + host_id_t'(1);
      if (!w_locked && dev_req_o && !dev_gnt_i) r_lock_id <= w_winner;
      if (dev_rvalid_i && w_empty) r_protocol_err <= 1'b1;
    end
  end

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_accept),
    .i_data  (w_winner[IdW-1:0]),
    .i_pop   (w_resp),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter with three hosts and two outstanding slots.
module tb_bus_host_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [2:0][31:0] host_addr, host_wdata, host_rdata;
  logic [2:0][3:0]  host_be;
  logic             dev_req, dev_gnt, dev_we, dev_rvalid, dev_err;
  logic [31:0]      dev_addr, dev_wdata, dev_rdata;
  logic [3:0]       dev_be;
  logic [1:0]       outstanding;
  logic             protocol_err;
  logic [2:0]       exp_gnt, exp_rv;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts        (3),
    .DataWidth      (32),
    .AddressWidth   (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .host_req_i     (host_req),
    .host_gnt_o     (host_gnt),
    .host_addr_i    (host_addr),
    .host_we_i      (host_we),
    .host_be_i      (host_be),
    .host_wdata_i   (host_wdata),
    .host_rvalid_o  (host_rvalid),
    .host_rdata_o   (host_rdata),
    .host_err_o     (host_err),
    .dev_req_o      (dev_req),
    .dev_gnt_i      (dev_gnt),
    .dev_addr_o     (dev_addr),
    .dev_we_o       (dev_we),
    .dev_be_o       (dev_be),
    .dev_wdata_o    (dev_wdata),
    .dev_rvalid_i   (dev_rvalid),
    .dev_rdata_i    (dev_rdata),
    .dev_err_i      (dev_err),
    .outstanding_o  (outstanding),
    .protocol_err_o (protocol_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    host_req = '0; dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = '0;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    step(); step();
    #1;
    if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_proterr got=%b exp=0", protocol_err); end
    checks++;
    if ({dev_req, host_gnt, host_rvalid, host_err} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {dev_req, host_gnt, host_rvalid, host_err});
    end
    checks++;
    if (dev_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", dev_addr); end
    checks++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_round_robin;
    host_req = 3'b111; dev_gnt = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) host_req = '0;
      dev_rvalid = (k > 0);
      dev_rdata  = 32'h5000_0000 + 32'(k);
      #1;
      exp_gnt = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
      exp_rv  = (k > 0) ? (3'b001 << ((k - 1) % 3)) : 3'b000;
      if (host_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, host_gnt, exp_gnt); end
      checks++;
      if (host_rvalid !== exp_rv) begin errors++; $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, host_rvalid, exp_rv); end
      checks++;
      if (host_err !== 3'b000) begin errors++; $display("FAIL rr_err k=%0d got=%b exp=000", k, host_err); end
      checks++;
      if (k < 6) begin
        if ({dev_addr, dev_wdata, dev_be, dev_we} !== {host_addr[k%3], host_wdata[k%3], host_be[k%3], host_we[k%3]}) begin
          errors++; $display("FAIL rr_fields k=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", k, dev_addr, dev_wdata, dev_be, dev_we,
                             host_addr[k%3], host_wdata[k%3], host_be[k%3], host_we[k%3]);
        end
        checks++;
      end
      step();
    end
    idle();
    #1;
    if (outstanding !== 2'd0) begin errors++; $display("FAIL rr_drain got=%0d exp=0", outstanding); end
    checks++;
    if (dev_addr !== 32'h0) begin errors++; $display("FAIL rr_noreq_addr got=%h exp=0", dev_addr); end
    checks++;
  endtask

  task automatic test_stall_lock;
    host_req = 3'b010;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) host_req = 3'b011;
      dev_gnt = (k == 4);
      #1;
      exp_gnt = (k == 4) ? 3'b010 : 3'b000;
      if (dev_req !== 1'b1 || dev_addr !== host_addr[1]) begin
        errors++; $display("FAIL lock_hold k=%0d got=%b/%h exp=1/%h", k, dev_req, dev_addr, host_addr[1]);
      end
      checks++;
      if (host_gnt !== exp_gnt) begin errors++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, host_gnt, exp_gnt); end
      checks++;
      step();
    end
    #1;
    if (host_gnt !== 3'b001) begin errors++; $display("FAIL lock_next got=%b exp=001", host_gnt); end
    checks++;
    step();
    idle();
    dev_rvalid = 1'b1;
    #1;
    if (outstanding !== 2'd2) begin errors++; $display("FAIL lock_outstanding got=%0d exp=2", outstanding); end
    checks++;
    if (host_rvalid !== 3'b010) begin errors++; $display("FAIL lock_resp1 got=%b exp=010", host_rvalid); end
    checks++;
    step();
    if (host_rvalid !== 3'b001) begin errors++; $display("FAIL lock_resp2 got=%b exp=001", host_rvalid); end
    checks++;
    step();
    idle();
    #1;
  endtask

  task automatic test_full;
    host_req = 3'b101; dev_gnt = 1'b1;
    #1;
    if (host_gnt !== 3'b100) begin errors++; $display("FAIL full_gnt1 got=%b exp=100", host_gnt); end
    checks++;
    step();
    if (host_gnt !== 3'b001) begin errors++; $display("FAIL full_gnt2 got=%b exp=001", host_gnt); end
    checks++;
    step();
    if (dev_req !== 1'b0 || host_gnt !== 3'b000 || outstanding !== 2'd2) begin
      errors++; $display("FAIL full_block got=%b/%b/%0d exp=0/000/2", dev_req, host_gnt, outstanding);
    end
    checks++;
    step();
    dev_rvalid = 1'b1;
    #1;
    if (host_rvalid !== 3'b100 || dev_req !== 1'b0) begin
      errors++; $display("FAIL full_resp1 got=%b/%b exp=100/0", host_rvalid, dev_req);
    end
    checks++;
    step();
    dev_rvalid = 1'b0;
    #1;
    if (outstanding !== 2'd1 || host_gnt !== 3'b100) begin
      errors++; $display("FAIL full_regrant got=%0d/%b exp=1/100", outstanding, host_gnt);
    end
    checks++;
    step();
    host_req = '0; dev_rvalid = 1'b1;
    #1;
    if (host_rvalid !== 3'b001 || outstanding !== 2'd2) begin
      errors++; $display("FAIL full_resp2 got=%b/%0d exp=001/2", host_rvalid, outstanding);
    end
    checks++;
    step();
    if (host_rvalid !== 3'b100) begin errors++; $display("FAIL full_resp3 got=%b exp=100", host_rvalid); end
    checks++;
    step();
    idle();
    #1;
    if (outstanding !== 2'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", outstanding); end
    checks++;
  endtask

  task automatic test_error_routing;
    host_req = 3'b100; dev_gnt = 1'b1;
    #1;
    if (host_gnt !== 3'b100 || dev_we !== 1'b0) begin
      errors++; $display("FAIL err_gnt got=%b/%b exp=100/0", host_gnt, dev_we);
    end
    checks++;
    step();
    idle();
    dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'hCAFE_F00D;
    #1;
    if (host_rvalid !== 3'b100 || host_err !== 3'b100) begin
      errors++; $display("FAIL err_route got=%b/%b exp=100/100", host_rvalid, host_err);
    end
    checks++;
    if (host_rdata[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_rdata got=%h exp=cafef00d", host_rdata[0]); end
    checks++;
    step();
    idle();
    #1;
  endtask

  task automatic test_stray;
    dev_rvalid = 1'b1;
    #1;
    if (host_rvalid !== 3'b000 || protocol_err !== 1'b0) begin
      errors++; $display("FAIL stray_rvalid got=%b/%b exp=000/0", host_rvalid, protocol_err);
    end
    checks++;
    step();
    dev_rvalid = 1'b0;
    step(); step();
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL stray_sticky got=%b exp=1", protocol_err); end
    checks++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL stray_clear got=%b exp=0", protocol_err); end
    checks++;
  endtask

  task automatic test_reset_midop;
    host_req = 3'b010; dev_gnt = 1'b1;
    #1;
    if (host_gnt !== 3'b010) begin errors++; $display("FAIL mid_gnt got=%b exp=010", host_gnt); end
    checks++;
    step();
    idle();
    #1;
    if (outstanding !== 2'd1) begin errors++; $display("FAIL mid_pending got=%0d exp=1", outstanding); end
    checks++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    if (outstanding !== 2'd0 || host_gnt !== 3'b000) begin
      errors++; $display("FAIL mid_reset got=%0d/%b exp=0/000", outstanding, host_gnt);
    end
    checks++;
    host_req = 3'b101; dev_gnt = 1'b1;
    #1;
    if (host_gnt !== 3'b001) begin errors++; $display("FAIL mid_ptr got=%b exp=001", host_gnt); end
    checks++;
    step();
    idle();
    dev_rvalid = 1'b1;
    #1;
    if (host_rvalid !== 3'b001) begin errors++; $display("FAIL mid_resp got=%b exp=001", host_rvalid); end
    checks++;
    step();
    idle();
    #1;
    if (outstanding !== 2'd0) begin errors++; $display("FAIL mid_drain got=%0d exp=0", outstanding); end
    checks++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      host_addr[i]  = 32'hA000_0000 | (32'(i) << 4);
      host_wdata[i] = 32'hD000_0000 | 32'(i);
      host_be[i]    = 4'h1 << i;
    end
    host_we = 3'b010;
    rst_n   = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_stall_lock();
    test_full();
    test_error_routing();
    test_stray();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
